// File: rtl/ex_logic_unit.sv
// Registered 3-input truth-table evaluator with edge pulses and a saturating toggle counter.
// Optional macro EX_INPUT_SYNC_EN adds a 2-flop synchronizer on A, B, C ahead of evaluation.
module ex_logic_unit #(
    parameter logic [7:0] TRUTH_TABLE = 8'b1110_1000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             F,
    output logic [2:0]       minterm,
    output logic             f_rise,
    output logic             f_fall,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [2:0]       idx;
    logic             f_q, f_d;
    logic [2:0]       minterm_q, minterm_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef EX_INPUT_SYNC_EN
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = {A, B, C};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign idx = sync2_q;
`else
    assign idx = {A, B, C};
`endif

    // f_q doubles as the previous-F reference for edge detection.
    always_comb begin
        f_d       = TRUTH_TABLE[idx];
        minterm_d = idx;
        rise_d    = ~f_q & f_d;
        fall_d    = f_q & ~f_d;
        cnt_d     = cnt_q;
        if ((rise_d || fall_d) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q       <= 1'b0;
            minterm_q <= 3'b000;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            f_q       <= f_d;
            minterm_q <= minterm_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            cnt_q     <= cnt_d;
        end
    end

    assign F          = f_q;
    assign minterm    = minterm_q;
    assign f_rise     = rise_q;
    assign f_fall     = fall_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_ex_logic_unit.sv
// Directed bench for ex_logic_unit: default CNT_W instance plus a CNT_W=4 instance for saturation.
module tb_ex_logic_unit;

`ifdef EX_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        A = 1'b0, B = 1'b0, C = 1'b0;
    logic        F, f_rise, f_fall;
    logic [2:0]  minterm;
    logic [15:0] toggle_cnt;
    logic        F4, f_rise4, f_fall4;
    logic [2:0]  minterm4;
    logic [3:0]  toggle_cnt4;

    int checks   = 0;
    int failures = 0;

    // Majority function, written out by hand per minterm.
    int exp_f[8]    = '{0, 0, 0, 1, 0, 1, 1, 1};
    int exp_rise[8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    int exp_fall[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int exp_cnt[8]  = '{0, 0, 0, 1, 2, 3, 3, 3};

    ex_logic_unit dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .F(F), .minterm(minterm), .f_rise(f_rise), .f_fall(f_fall),
        .toggle_cnt(toggle_cnt)
    );

    ex_logic_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .F(F4), .minterm(minterm4), .f_rise(f_rise4), .f_fall(f_fall4),
        .toggle_cnt(toggle_cnt4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int f, input int m, input int r,
                           input int fa, input int c);
        chk({tag, ".F"}, 32'(F), 32'(f));
        chk({tag, ".minterm"}, 32'(minterm), 32'(m));
        chk({tag, ".f_rise"}, 32'(f_rise), 32'(r));
        chk({tag, ".f_fall"}, 32'(f_fall), 32'(fa));
        chk({tag, ".cnt"}, 32'(toggle_cnt), 32'(c));
    endtask

    task automatic set_in(input logic [2:0] v);
        {A, B, C} = v;
    endtask

    initial begin
        int j;
        int c4;
        logic [2:0] v;

        // Reset state
        rst = 1'b1;
        set_in(3'b000);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset.cnt4", 32'(toggle_cnt4), 32'd0);
        rst = 1'b0;

        // Hold 000 for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("hold000", 0, 0, 0, 0, 0);
        end

        // Sweep 000..111, each held 10 cycles
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            set_in(v);
            for (int k = 0; k < LAT; k++) tick();
            chk_all($sformatf("sweep%0d", i), exp_f[i], i, exp_rise[i], exp_fall[i], exp_cnt[i]);
            for (int k = LAT; k < 10; k++) tick();
            chk_all($sformatf("sweep%0d_held", i), exp_f[i], i, 0, 0, exp_cnt[i]);
        end

        // Glitch between edges is ignored: F stays 1 on held 111
        tick();
        set_in(3'b000);
        #2;
        set_in(3'b111);
        tick();
        chk_all("glitch", 1, 7, 0, 0, 3);

        // Clean reset, then toggle 011<->100 every cycle for 20 transitions
        rst = 1'b1;
        set_in(3'b000);
        tick();
        rst = 1'b0;
        for (int k = 0; k < LAT; k++) tick();
        chk_all("pre_toggle", 0, 0, 0, 0, 0);
        for (int t = 0; t < 20 + LAT - 1; t++) begin
            if (t < 20) set_in((t % 2 == 0) ? 3'b011 : 3'b100);
            tick();
            j = t - (LAT - 1);
            if (j >= 0) begin
                chk_all($sformatf("toggle%0d", j), (j % 2 == 0) ? 1 : 0,
                        (j % 2 == 0) ? 3 : 4, (j % 2 == 0) ? 1 : 0,
                        (j % 2 == 0) ? 0 : 1, j + 1);
                c4 = (j + 1 > 15) ? 15 : j + 1;
                chk($sformatf("toggle%0d.cnt4", j), 32'(toggle_cnt4), 32'(c4));
            end
        end
        for (int k = 0; k < 4; k++) tick();
        chk_all("toggle_end", 0, 4, 0, 0, 20);
        chk("toggle_end.cnt4", 32'(toggle_cnt4), 32'd15);

        // Mid-operation reset with inputs 111 and F=1
        set_in(3'b111);
        for (int k = 0; k < LAT; k++) tick();
        chk_all("pre_rst", 1, 7, 1, 0, 21);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 0, 0, 0, 0, 0);
        chk("mid_rst.cnt4", 32'(toggle_cnt4), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            tick();
            chk_all($sformatf("post_rst_wait%0d", k), 0, 0, 0, 0, 0);
        end
        tick();
        chk_all("post_rst", 1, 7, 1, 0, 1);
        chk("post_rst.cnt4", 32'(toggle_cnt4), 32'd1);
        tick();
        chk_all("post_rst_held", 1, 7, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_logic_unit.md
Name: ex_logic_unit

Overview:
- Registered 3-input Boolean function evaluator. F = TRUTH_TABLE[{A,B,C}], sampled on the clock.
- The default table implements the 3-input majority function.
- Also reports the sampled minterm index, edge pulses on F, and a saturating count of F transitions.
- Used as a small glue-logic/decode leaf anywhere a registered 3-input function is needed.

Parameters:
- TRUTH_TABLE, 8'b1110_1000: bit i is F for minterm i = {A,B,C}. Default is majority, so F=1 for minterms 3, 5, 6, 7.
- CNT_W, 16: width of toggle_cnt.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  1  function input, MSB of the minterm index.
- B  input  1  function input, middle bit of the minterm index.
- C  input  1  function input, LSB of the minterm index.
- F  output  1  registered function result.
- minterm  output  3  registered {A,B,C} that produced the current F.
- f_rise  output  1  one-cycle pulse when registered F goes 0->1.
- f_fall  output  1  one-cycle pulse when registered F goes 1->0.
- toggle_cnt  output  CNT_W  saturating count of F transitions since reset.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. No asynchronous reset path anywhere.
- Reset (rst=1 at a rising clk edge) clears all outputs:
  - F=0, minterm=3'b000, f_rise=0, f_fall=0, toggle_cnt=0.
  - The internal previous-F register is also cleared to 0.
- Reset takes priority over every other update in the same cycle.
- Evaluation:
  - idx = {A,B,C}; next_F = TRUTH_TABLE[idx].
  - On each non-reset edge: F <= next_F and minterm <= idx.
  - Latency from input change to F is 1 clock edge.
- Edge detect compares next_F with current F:
  - f_rise <= (~F & next_F); f_fall <= (F & ~next_F).
  - Pulses are coincident with the F update and last exactly one cycle.
  - f_rise and f_fall are never both 1.
- Counter:
  - toggle_cnt increments by 1 on any cycle in which f_rise or f_fall is being asserted.
  - It holds at 2^CNT_W-1; no wrap.
- Held inputs produce a stable F: no pulses and no count change.
- Input changes between clock edges are ignored. Only the value present at the edge matters; inputs are glitch-insensitive.
- First cycle after reset release with next_F=1:
  - F rises and f_rise=1, because the pre-reset F is defined as 0.
  - Counter becomes 1.
- Reset asserted mid-operation: on that edge all outputs return to reset values, regardless of A, B, C.

Optional Feature:
- Macro EX_INPUT_SYNC_EN.
- When defined:
  - A, B, C pass through a 2-flop synchronizer per bit, clocked by clk, before evaluation.
  - Synchronizer flops reset to 0 on rst.
  - Total input-to-F latency becomes 3 edges.
  - minterm reports the synchronized index.
- When undefined: no synchronizer; latency is 1 edge as above.
- Edge, counter and reset rules are identical in both builds.

Test Plan:
- Reset, then hold A,B,C=0,0,0 for 5 cycles -> F=0, minterm=0, no pulses, toggle_cnt=0.
- Exhaustive sweep of {A,B,C} from 000 to 111, each held 10 cycles -> F sequence 0,0,0,1,0,1,1,1.
  - minterm tracks the index 1 edge later.
  - f_rise at 011, f_fall at 100, f_rise at 101.
  - toggle_cnt=3 at end.
- Toggle 011<->100 every cycle from F=0 -> F alternates each cycle, alternating single-cycle f_rise/f_fall.
  - After 20 transitions toggle_cnt=20.
- Assert rst for 1 cycle while inputs=111 and F=1 -> next edge F=0, toggle_cnt=0, no f_fall.
  - After release, F=1 with f_rise=1 and toggle_cnt=1.
- CNT_W=4, toggle inputs 20 times -> toggle_cnt saturates at 15 and stays there.
- Build with EX_INPUT_SYNC_EN, step 000->111 -> F goes to 1 exactly on the 3rd edge after the change.
